// File: rtl/sysad_slave_if.sv
// SysAD pin bundle plus the backend request/data port of the external agent.
// slave = the agent (RCP side); master = CPU pins and backend driven from outside.
interface sysad_slave_if;
  logic [31:0] sysad_in;
  logic [4:0]  syscmd_in;
  logic        pvalid_l;
  logic [31:0] sysad_out;
  logic [4:0]  syscmd_out;
  logic        sysad_oe;
  logic        eok_l;
  logic        evalid_l;
  logic        be_req;
  logic        be_write;
  logic        be_block;
  logic [1:0]  be_size;
  logic [31:0] be_addr;
  logic        be_ack;
  logic [2:0]  be_widx;
  logic [31:0] be_wdata;
  logic        be_rvalid;
  logic [31:0] be_rdata;
  logic        be_rerr;
  logic        proto_err;

  modport slave (
    input  sysad_in, syscmd_in, pvalid_l, be_ack, be_widx, be_rvalid, be_rdata, be_rerr,
    output sysad_out, syscmd_out, sysad_oe, eok_l, evalid_l, be_req, be_write, be_block,
           be_size, be_addr, be_wdata, proto_err
  );

  modport master (
    output sysad_in, syscmd_in, pvalid_l, be_ack, be_widx, be_rvalid, be_rdata, be_rerr,
    input  sysad_out, syscmd_out, sysad_oe, eok_l, evalid_l, be_req, be_write, be_block,
           be_size, be_addr, be_wdata, proto_err
  );
endinterface

// File: rtl/sysad_slave.sv
// External-agent end of the VR4300 SysAD bus: decodes CPU read/write requests,
// buffers write words, issues one backend request and replays read words to the CPU.
module sysad_slave #(
  parameter int TURN_CYC = 1
) (
  input logic         sysclk,
  input logic         reset,
  sysad_slave_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WISSUE, S_RACK, S_RTURN, S_RRESP, S_RLAST
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_block, r_write, r_req, r_acked;
  logic [3:0]  r_nexp, r_wcnt, r_rcnt;
  logic [1:0]  r_turn;
  logic        r_eok_l, r_evalid_l, r_oe, r_perr;
  logic [31:0] r_sysad_out;
  logic [4:0]  r_syscmd_out;
  logic [31:0] r_wbuf [8];

  logic       w_cmd, w_data, w_last, w_bad, w_wstore, w_acked, w_rtake, w_rlast;
  logic       w_capture, w_req_set, w_req_nxt, w_perr;
  logic [3:0] w_dec_nexp;

  assign w_cmd    = !bus.pvalid_l && !bus.syscmd_in[4];
  assign w_data   = !bus.pvalid_l &&  bus.syscmd_in[4];
  assign w_last   = !bus.syscmd_in[3];
  assign w_bad    = bus.syscmd_in[2] && (bus.syscmd_in[1:0] == 2'b11);
  assign w_wstore = (r_state == S_WDATA) && w_data && (r_wcnt < r_nexp);
  assign w_acked  = r_acked || (r_req && bus.be_ack);
  // A read word is only meaningful once the backend has taken the request.
  assign w_rtake  = (r_state == S_RRESP) && bus.be_rvalid && w_acked;
  assign w_rlast  = (r_rcnt + 4'd1) == r_nexp;

  always_comb begin
    w_dec_nexp = 4'd1;
    if (bus.syscmd_in[2]) begin
      case (bus.syscmd_in[1:0])
        2'b00:   w_dec_nexp = 4'd2;
        2'b01:   w_dec_nexp = 4'd4;
        default: w_dec_nexp = 4'd8;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_req_set   = 1'b0;
    w_perr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd && !r_eok_l) begin
          if (w_bad) w_perr = 1'b1;
          else begin
            w_capture   = 1'b1;
            w_state_nxt = bus.syscmd_in[3] ? S_WDATA : S_RACK;
          end
        end else if (w_data) w_perr = 1'b1;
      end
      S_WDATA: begin
        if (w_data) begin
          if (!w_wstore) w_perr = 1'b1;
          if (w_last) begin
            if ((r_wcnt + 4'd1) != r_nexp) begin
              w_perr      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_req_set   = 1'b1;
              w_state_nxt = S_WISSUE;
            end
          end
        end
      end
      S_WISSUE: if (bus.be_ack) w_state_nxt = S_IDLE;
      S_RACK: begin
        w_req_set   = 1'b1;
        w_state_nxt = S_RTURN;
      end
      S_RTURN:  if (r_turn <= 2'd1) w_state_nxt = S_RRESP;
      S_RRESP:  if (w_rtake && w_rlast) w_state_nxt = S_RLAST;
      S_RLAST:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_cmd && (r_state inside {S_WISSUE, S_RACK, S_RTURN, S_RRESP, S_RLAST})) w_perr = 1'b1;
    if (bus.be_rvalid && !w_rtake) w_perr = 1'b1;
    w_req_nxt = w_req_set || (r_req && !bus.be_ack);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_size       <= '0;
      r_block      <= 1'b0;
      r_write      <= 1'b0;
      r_req        <= 1'b0;
      r_acked      <= 1'b0;
      r_nexp       <= '0;
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      r_turn       <= '0;
      r_eok_l      <= 1'b1;
      r_evalid_l   <= 1'b1;
      r_oe         <= 1'b0;
      r_perr       <= 1'b0;
      r_sysad_out  <= '0;
      r_syscmd_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_addr  <= bus.sysad_in;
        r_size  <= bus.syscmd_in[1:0];
        r_block <= bus.syscmd_in[2];
        r_write <= bus.syscmd_in[3];
        r_nexp  <= w_dec_nexp;
        r_wcnt  <= '0;
        r_rcnt  <= '0;
      end
      if (w_wstore) r_wcnt <= r_wcnt + 4'd1;
      r_req <= w_req_nxt;
      if (w_req_set) r_acked <= 1'b0;
      else if (r_req && bus.be_ack) r_acked <= 1'b1;
      if (r_state == S_RACK) r_turn <= 2'(TURN_CYC);
      else if (r_state == S_RTURN) r_turn <= r_turn - 2'd1;
      // eok_l follows the state being entered so the CPU sees it on the same edge.
      r_eok_l <= !(((w_state_nxt == S_IDLE) && !w_req_nxt) ||
                   (w_state_nxt == S_WDATA) || (w_state_nxt == S_RACK));
      r_oe       <= (w_state_nxt == S_RRESP) || (w_state_nxt == S_RLAST);
      r_evalid_l <= !w_rtake;
      r_perr     <= w_perr;
      if (w_rtake) begin
        r_sysad_out  <= bus.be_rdata;
        r_syscmd_out <= {1'b1, !w_rlast, 1'b0, bus.be_rerr, 1'b0};
        r_rcnt       <= r_rcnt + 4'd1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_wstore) r_wbuf[r_wcnt[2:0]] <= bus.sysad_in;
  end

  assign bus.sysad_out  = r_sysad_out;
  assign bus.syscmd_out = r_syscmd_out;
  assign bus.sysad_oe   = r_oe;
  assign bus.eok_l      = r_eok_l;
  assign bus.evalid_l   = r_evalid_l;
  assign bus.be_req     = r_req;
  assign bus.be_write   = r_write;
  assign bus.be_block   = r_block;
  assign bus.be_size    = r_size;
  assign bus.be_addr    = r_addr;
  assign bus.be_wdata   = r_wbuf[bus.be_widx];
  assign bus.proto_err  = r_perr;

endmodule

// File: tb/tb_sysad_slave.sv
// Bench for sysad_slave: CPU writes/reads driven at the pins, read responses
// scored against a queue filled when the backend delivers each word.
module tb_sysad_slave;
  logic sysclk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_err = 0, n_resp = 0;
  logic [36:0] rq[$];
  logic [31:0] wq[$];

  sysad_slave_if bus();
  sysad_slave #(.TURN_CYC(1)) dut (.sysclk(sysclk), .reset(rst), .bus(bus));

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysclk); #1;
  endtask

  // Read-response scoreboard: one entry per evalid_l pulse.
  always @(negedge sysclk) begin
    if (!rst && bus.evalid_l === 1'b0) begin
      logic [36:0] e;
      n_resp++;
      chk("rq_avail", 32'(rq.size() > 0), 32'd1);
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("resp_data", bus.sysad_out, e[31:0]);
        chk("resp_cmd", 32'(bus.syscmd_out), 32'(e[36:32]));
        chk("resp_oe", 32'(bus.sysad_oe), 32'd1);
      end
    end
  end

  task automatic cpu_cmd(input logic [4:0] cmd, input logic [31:0] addr);
    int t = 0;
    while (bus.eok_l !== 1'b0 && t < 50) begin tick; t++; end
    chk("eok_wait", 32'(bus.eok_l), 32'd0);
    bus.pvalid_l = 1'b0; bus.syscmd_in = cmd; bus.sysad_in = addr;
    tick;
    bus.pvalid_l = 1'b1; bus.syscmd_in = '0;
  endtask

  task automatic cpu_data(input logic [31:0] d, input logic last);
    bus.pvalid_l = 1'b0; bus.syscmd_in = {1'b1, !last, 3'b000}; bus.sysad_in = d;
    tick;
    bus.pvalid_l = 1'b1; bus.syscmd_in = '0;
  endtask

  task automatic do_write(input logic blk, input logic [1:0] sz, input logic [31:0] addr,
                          input int nw, input int nexp);
    logic [31:0] d;
    cpu_cmd({2'b01, blk, sz}, addr);
    wq.delete();
    for (int i = 0; i < nw; i++) begin
      d = (nw == 1) ? 32'hdeadbeef : 32'(i);
      if (i < nexp) wq.push_back(d);
      cpu_data(d, i == nw - 1);
    end
    if (nw != nexp) begin
      chk("wr_perr", 32'(bus.proto_err), 32'd1);
      chk("wr_noreq", 32'(bus.be_req), 32'd0);
      tick;
      chk("wr_perr_pulse", 32'(bus.proto_err), 32'd0);
      chk("wr_eok_back", 32'(bus.eok_l), 32'd0);
      return;
    end
    chk("wr_req", 32'(bus.be_req), 32'd1);
    chk("wr_write", 32'(bus.be_write), 32'd1);
    chk("wr_block", 32'(bus.be_block), 32'(blk));
    chk("wr_size", 32'(bus.be_size), 32'(sz));
    chk("wr_addr", bus.be_addr, addr);
    chk("wr_eok_busy", 32'(bus.eok_l), 32'd1);
    for (int i = 0; i < nexp; i++) begin
      bus.be_widx = 3'(i); #1;
      chk("wr_wdata", bus.be_wdata, wq.pop_front());
    end
    tick; tick;
    chk("wr_req_hold", 32'(bus.be_req), 32'd1);
    chk("wr_eok_hold", 32'(bus.eok_l), 32'd1);
    bus.be_ack = 1'b1; tick; bus.be_ack = 1'b0;
    chk("wr_req_drop", 32'(bus.be_req), 32'd0);
    chk("wr_eok_ready", 32'(bus.eok_l), 32'd0);
  endtask

  task automatic do_read(input logic blk, input logic [1:0] sz, input logic [31:0] addr,
                         input int nw, input int lat, input int gap, input logic [7:0] errm);
    int r0 = n_resp;
    logic [31:0] d;
    cpu_cmd({2'b00, blk, sz}, addr);
    chk("rd_rack_eok", 32'(bus.eok_l), 32'd0);
    tick;
    chk("rd_req", 32'(bus.be_req), 32'd1);
    chk("rd_write", 32'(bus.be_write), 32'd0);
    chk("rd_addr", bus.be_addr, addr);
    chk("rd_eok", 32'(bus.eok_l), 32'd1);
    repeat (lat) tick;
    bus.be_ack = 1'b1; tick; bus.be_ack = 1'b0;
    chk("rd_req_drop", 32'(bus.be_req), 32'd0);
    for (int i = 0; i < nw; i++) begin
      d = 32'h12345678 + 32'(i * 32'h01010101);
      bus.be_rvalid = 1'b1; bus.be_rdata = d; bus.be_rerr = errm[i];
      rq.push_back({1'b1, i != nw - 1, 1'b0, errm[i], 1'b0, d});
      tick;
      bus.be_rvalid = 1'b0; bus.be_rerr = 1'b0;
      if (i < nw - 1) repeat (gap) tick;
    end
    tick;
    chk("rd_evalid_end", 32'(bus.evalid_l), 32'd1);
    chk("rd_oe_end", 32'(bus.sysad_oe), 32'd0);
    chk("rd_resp_cnt", 32'(n_resp - r0), 32'(nw));
    chk("rd_eok_ready", 32'(bus.eok_l), 32'd0);
  endtask

  initial begin
    bus.pvalid_l = 1'b1; bus.syscmd_in = '0; bus.sysad_in = '0;
    bus.be_ack = 1'b0; bus.be_widx = '0; bus.be_rvalid = 1'b0;
    bus.be_rdata = '0; bus.be_rerr = 1'b0;
    tick; tick;
    chk("rst_eok", 32'(bus.eok_l), 32'd1);
    chk("rst_evalid", 32'(bus.evalid_l), 32'd1);
    chk("rst_oe", 32'(bus.sysad_oe), 32'd0);
    chk("rst_req", 32'(bus.be_req), 32'd0);
    chk("rst_perr", 32'(bus.proto_err), 32'd0);
    chk("rst_sysad", bus.sysad_out, 32'd0);
    chk("rst_syscmd", 32'(bus.syscmd_out), 32'd0);
    rst = 1'b0;
    tick;
    chk("idle_eok", 32'(bus.eok_l), 32'd0);

    do_write(1'b0, 2'b11, 32'h04000010, 1, 1);
    do_write(1'b1, 2'b10, 32'h00200000, 8, 8);
    do_write(1'b1, 2'b10, 32'h00200100, 7, 8);
    do_read(1'b0, 2'b00, 32'h00100000, 1, 5, 0, 8'h00);
    do_read(1'b1, 2'b01, 32'h00100040, 4, 2, 2, 8'h01);

    // block size 11 is rejected at the command
    cpu_cmd(5'b00111, 32'h00300000);
    chk("bad_perr", 32'(bus.proto_err), 32'd1);
    chk("bad_noreq", 32'(bus.be_req), 32'd0);
    chk("bad_eok", 32'(bus.eok_l), 32'd0);
    tick;
    chk("bad_perr_pulse", 32'(bus.proto_err), 32'd0);

    // stray backend word while idle
    bus.be_rvalid = 1'b1; tick; bus.be_rvalid = 1'b0;
    chk("stray_rvalid_perr", 32'(bus.proto_err), 32'd1);
    chk("stray_rvalid_evalid", 32'(bus.evalid_l), 32'd1);

    // reset in the middle of a block read response
    cpu_cmd(5'b00100, 32'h00400000);
    tick;
    bus.be_ack = 1'b1; tick; bus.be_ack = 1'b0;
    bus.be_rvalid = 1'b1; bus.be_rdata = 32'ha5a5a5a5;
    rq.push_back({5'b11000, 32'ha5a5a5a5});
    tick;
    bus.be_rvalid = 1'b0;
    tick;
    chk("mid_oe", 32'(bus.sysad_oe), 32'd1);
    rst = 1'b1; #1;
    rq.delete();
    tick;
    chk("mrst_oe", 32'(bus.sysad_oe), 32'd0);
    chk("mrst_evalid", 32'(bus.evalid_l), 32'd1);
    chk("mrst_req", 32'(bus.be_req), 32'd0);
    rst = 1'b0;
    tick;
    do_read(1'b0, 2'b10, 32'h00500000, 1, 1, 0, 8'h00);

    repeat (3) tick;
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
